// File: rtl/add6to3_accum_pkg.sv
// Shared types and constants for the iterative 6:3 carry-save accumulator.
package add6to3_accum_pkg;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Weights of the second and third carry-save vectors relative to the first.
    localparam int unsigned SHIFT_1 = 1;
    localparam int unsigned SHIFT_2 = 2;

endpackage

// File: rtl/add6to3.sv
// 6:3 per-bit counter array.
// Each bit column counts the ones among its six inputs and reports the 3-bit
// count in place, so that i0+..+i5 == o0_c + (o1_c<<1) + (o2_c<<2) (mod 2^WIDTH).
// Ports:
//   i0..i5   in   WIDTH  operands
//   o0_c     out  WIDTH  weight-1 bit of each column count
//   o1_c     out  WIDTH  weight-2 bit of each column count
//   o2_c     out  WIDTH  weight-4 bit of each column count
module add6to3 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    output logic [WIDTH-1:0] o0_c,
    output logic [WIDTH-1:0] o1_c,
    output logic [WIDTH-1:0] o2_c
);

    for (genvar j = 0; j < int'(WIDTH); j++) begin : g_col
        logic [2:0] col_cnt;

        // Population count of one bit column (0..6).
        assign col_cnt = 3'(i0[j]) + 3'(i1[j]) + 3'(i2[j])
                       + 3'(i3[j]) + 3'(i4[j]) + 3'(i5[j]);
        assign o0_c[j] = col_cnt[0];
        assign o1_c[j] = col_cnt[1];
        assign o2_c[j] = col_cnt[2];
    end

endmodule

// File: rtl/add6to3_accum.sv
// Iterative multi-operand accumulator: three operands per beat are folded into
// a carry-save triple (s0, s1, s2) through one shared add6to3 array; after the
// last beat a single carry-propagate add resolves the sum (mod 2^WIDTH).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready beat handshake; in_a/in_b/in_c operands, in_last final beat
//   out_valid/out_ready result handshake
//   out_sum           resolved sum, modulo 2^WIDTH
//   out_beats         beats accepted, saturating at 2^CNT_W-1
module add6to3_accum
    import add6to3_accum_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_beats
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s0_q, s1_q, s2_q;
    logic [WIDTH-1:0] s0_d, s1_d, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_d;
    logic             valid_d;
    logic             ready_d;

    logic [WIDTH-1:0] fb1, fb2;
    logic [WIDTH-1:0] o0, o1, o2;
    logic             hs;
    logic [CNT_W-1:0] cnt_inc;

    // Re-weight the redundant feedback; bits shifted past WIDTH-1 are dropped.
    assign fb1     = s1_q << SHIFT_1;
    assign fb2     = s2_q << SHIFT_2;
    assign hs      = in_valid && in_ready;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    add6to3 #(
        .WIDTH (WIDTH)
    ) u_add6to3 (
        .i0   (s0_q),
        .i1   (fb1),
        .i2   (fb2),
        .i3   (in_a),
        .i4   (in_b),
        .i5   (in_c),
        .o0_c (o0),
        .o1_c (o1),
        .o2_c (o2)
    );

    // Next-state and next-value logic.
    always_comb begin
        state_d = state_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        cnt_d   = cnt_q;
        sum_d   = out_sum;
        valid_d = 1'b0;
        ready_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Feedback is zero here, so the array sums only the new beat.
                if (hs) begin
                    s0_d    = o0;
                    s1_d    = o1;
                    s2_d    = o2;
                    cnt_d   = CNT_W'(1);
                    state_d = in_last ? RESOLVE : ACCUM;
                end
            end
            ACCUM: begin
                if (hs) begin
                    s0_d  = o0;
                    s1_d  = o1;
                    s2_d  = o2;
                    cnt_d = cnt_inc;
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                sum_d   = s0_q + fb1 + fb2;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    s0_d    = '0;
                    s1_d    = '0;
                    s2_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered from the upcoming state.
        valid_d = (state_d == DONE);
        ready_d = (state_d == IDLE) || (state_d == ACCUM);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s0_q      <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            cnt_q     <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cnt_q     <= cnt_d;
            out_sum   <= sum_d;
            out_valid <= valid_d;
            in_ready  <= ready_d;
        end
    end

    assign out_beats = cnt_q;

endmodule

// File: tb/tb_add6to3_accum.sv
// Scoreboard bench for add6to3_accum (WIDTH=8, CNT_W=4 to exercise wrap and saturation).
module tb_add6to3_accum;

    localparam int unsigned TW = 8;
    localparam int unsigned TC = 4;
    localparam longint unsigned MASK     = (64'd1 << TW) - 64'd1;
    localparam int              BEAT_MAX = (1 << TC) - 1;

    typedef struct {
        logic [TW-1:0] sum;
        logic [TC-1:0] beats;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TW-1:0] in_a = '0;
    logic [TW-1:0] in_b = '0;
    logic [TW-1:0] in_c = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [TW-1:0] out_sum;
    logic [TC-1:0] out_beats;

    exp_t            exp_q[$];
    int              checks = 0;
    int              errors = 0;
    longint unsigned m_sum = 0;
    int              m_beats = 0;
    bit              bp = 1'b0;
    bit              rnd_rdy = 1'b0;

    add6to3_accum #(
        .WIDTH (TW),
        .CNT_W (TC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats)
    );

    always #5 clk = ~clk;

    // Consumer: ready policy applied shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bp)           out_ready = 1'b0;
        else if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        else              out_ready = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every result handshake is compared against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_sum", 64'(out_sum), 64'(e.sum));
                check("out_beats", 64'(out_beats), 64'(e.beats));
            end
        end
    end

    // Reference model: plain modular sum and saturating beat count.
    task automatic model_beat(input logic [TW-1:0] a, input logic [TW-1:0] b,
                              input logic [TW-1:0] c, input bit last);
        exp_t e;
        m_sum = (m_sum + longint'(a) + longint'(b) + longint'(c)) & MASK;
        m_beats++;
        if (last) begin
            e.sum   = TW'(m_sum);
            e.beats = TC'((m_beats > BEAT_MAX) ? BEAT_MAX : m_beats);
            exp_q.push_back(e);
            m_sum   = 0;
            m_beats = 0;
        end
    endtask

    // Offer one beat from a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [TW-1:0] a, input logic [TW-1:0] b,
                        input logic [TW-1:0] c, input bit last);
        bit ok = 1'b0;
        in_a = a; in_b = b; in_c = c; in_last = last; in_valid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (ok) model_beat(a, b, c, last);
        else    check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_valid(input logic lvl, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (out_valid === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check(name, 64'(out_valid), 64'(lvl));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_beats", 64'(out_beats), 64'd0);
        @(negedge clk);

        // Single beat, latency of out_valid.
        send(8'd1, 8'd2, 8'd3, 1'b1);
        check("lat_resolve_valid", 64'(out_valid), 64'd0);
        check("lat_resolve_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("lat_done_valid", 64'(out_valid), 64'd1);
        drain();

        // Three beats with a bubble; ready stays high in ACCUM.
        send(8'd1, 8'd1, 8'd1, 1'b0);
        check("accum_ready_bubble", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("accum_ready_hold", 64'(in_ready), 64'd1);
        send(8'd2, 8'd2, 8'd2, 1'b0);
        check("accum_ready_2", 64'(in_ready), 64'd1);
        send(8'd3, 8'd3, 8'd3, 1'b1);
        drain();

        // Wrap-around and long accumulation.
        send(8'hFF, 8'hFF, 8'hFF, 1'b1);
        drain();
        for (int i = 0; i < 100; i++) send(8'h80, 8'h80, 8'h80, bit'(i == 99));
        drain();

        // Backpressure in DONE: outputs stable, offered beats refused.
        bp = 1'b1;
        send(8'd9, 8'd8, 8'd7, 1'b1);
        wait_valid(1'b1, "bp_valid_timeout");
        in_a = 8'd99; in_b = 8'd99; in_c = 8'd99; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_sum", 64'(out_sum), 64'd24);
            check("bp_beats", 64'(out_beats), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        bp = 1'b0;
        wait_valid(1'b0, "bp_release_timeout");
        check("idle_after_done", 64'(in_ready), 64'd1);
        send(8'd4, 8'd5, 8'd6, 1'b1);
        drain();

        // Reset in the middle of an accumulation.
        send(8'd1, 8'd2, 8'd3, 1'b0);
        send(8'd4, 8'd5, 8'd6, 1'b0);
        rst = 1'b1;
        m_sum = 0;
        m_beats = 0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_sum", 64'(out_sum), 64'd0);
        check("mid_rst_out_beats", 64'(out_beats), 64'd0);
        send(8'd7, 8'd0, 8'd0, 1'b1);
        drain();

        // Beat counter saturation.
        for (int i = 0; i < 20; i++) send(8'd1, 8'd0, 8'd0, bit'(i == 19));
        drain();

        // Randomized accumulations with bubbles and random consumer stalls.
        rnd_rdy = 1'b1;
        for (int n = 0; n < 30; n++) begin
            int len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) begin
                send(TW'($urandom), TW'($urandom), TW'($urandom), bit'(i == len - 1));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        drain();
        rnd_rdy = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add6to3_accum.md
# add6to3_accum

Iterative multi-operand accumulator controller for the multiplier unit. It streams three WIDTH-bit operands per beat into one shared `add6to3` carry-save array and keeps the array's three outputs as feedback, so any number of beats costs one compressor. After the last beat it resolves the redundant form with a single carry-propagate add and returns the sum modulo 2^WIDTH over a valid/ready handshake. It sits between partial-product generation and the result register of the multiplier datapath.

## Interface
Parameters:
- `WIDTH`, 64: operand and result width; all arithmetic is modulo 2^WIDTH.
- `CNT_W`, 8: width of the beat counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the beat on `in_a`/`in_b`/`in_c` is valid.
- `in_ready`  out  1  the block accepts a beat this cycle.
- `in_a`, `in_b`, `in_c`  in  WIDTH  three operands of one beat.
- `in_last`  in  1  marks the final beat of an accumulation; sampled only on handshake.
- `out_valid`  out  1  the result is available.
- `out_ready`  in  1  the consumer takes the result.
- `out_sum`  out  WIDTH  sum of all operands in the accumulation, modulo 2^WIDTH.
- `out_beats`  out  CNT_W  number of beats accepted, saturating at 2^CNT_W-1.

## Operation
- States: IDLE, ACCUM, RESOLVE, DONE.
- Feedback registers are `s0`, `s1` and `s2`, each WIDTH bits.
- A handshake is `in_valid && in_ready`.
- `in_ready` is 1 in IDLE and in ACCUM, and 0 in RESOLVE and DONE.
- Compressor inputs on every accepted beat:
  - i0 = `s0`, i1 = `s1<<1`, i2 = `s2<<2`, all truncated to WIDTH.
  - i3 = `in_a`, i4 = `in_b`, i5 = `in_c`.
  - On a handshake the compressor outputs o0, o1 and o2 load into `s0`, `s1` and `s2`.
- In IDLE the feedback registers are zero, so the first beat sums only the new operands.
- Transitions:
  - IDLE, handshake without last: go to ACCUM, counter = 1.
  - IDLE, handshake with last: go to RESOLVE, counter = 1.
  - ACCUM, handshake: counter increments with saturation. Go to RESOLVE if `in_last`, otherwise stay in ACCUM.
  - ACCUM without a handshake: hold all state. Bubbles are legal.
  - RESOLVE: register `out_sum = s0 + (s1<<1) + (s2<<2)` truncated to WIDTH, then go to DONE.
  - DONE: `out_valid` = 1. On `out_ready` go to IDLE, clear `s0`, `s1`, `s2` and the counter, and clear `out_valid`.
- While `out_valid` is 1, `out_sum` and `out_beats` stay stable until the handshake completes.
- Carries out of bit WIDTH-1 are discarded; there is no overflow flag.
- Reset values: state IDLE; `s0`, `s1`, `s2`, `out_sum` and `out_beats` all 0; `out_valid` 0. `in_ready` is 1 from the first cycle after reset.
- Reset asserted mid-operation abandons the accumulation in the same edge; no output is produced for it.

## Timing
- If the last beat is accepted at cycle t, the state is RESOLVE at t+1 and `out_valid` rises at t+2.
- Minimum spacing between accumulations:
  - A single-beat accumulation occupies IDLE, RESOLVE and DONE, giving 3 cycles when `out_ready` is held at 1.
  - The next first beat can be accepted in the cycle after the DONE handshake.
- The throughput cap is intentional. There is no skid buffer, and `in_ready` has no combinational dependency on `out_ready`.
- Critical path: the compressor (6:3 per bit plus the feedback shifts) in ACCUM, and the WIDTH-bit 3-input adder in RESOLVE. These paths are never active in the same cycle.
- `out_ready` asserted in any state other than DONE has no effect.

## Structure
- Package `add6to3_accum_pkg` holds:
  - the state enum (IDLE, ACCUM, RESOLVE, DONE) as a 2-bit typedef;
  - localparams for the shift amounts (1 and 2).
- The one sub-module is the existing `add6to3`, instantiated once with WIDTH = `WIDTH`.
- The FSM, counter, feedback registers and final adder stay in this module.

## Test plan
- Single beat with WIDTH=64: (1,2,3) with `in_last` → `out_valid` rises 2 cycles after the handshake, `out_sum`=6, `out_beats`=1.
- Three beats: (1,1,1), (2,2,2), (3,3,3, last), with one idle cycle inserted between the first two → `out_sum`=18, `out_beats`=3; `in_ready` stays 1 throughout ACCUM.
- Wrap with WIDTH=8: one beat (0xFF,0xFF,0xFF, last) → `out_sum`=0xFD. Then 100 beats of (0x80,0x80,0x80) → `out_sum`=0x00, `out_beats`=100.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_sum` and `out_beats` stable, `in_ready`=0, offered beats not consumed. Then `out_ready`=1 → IDLE next cycle, and a new beat (4,5,6, last) yields 15.
- Reset mid-operation: accept two beats, assert `rst` for one cycle → all outputs 0 and `in_ready`=1. A subsequent beat (7,0,0, last) yields 7.
- Counter saturation with CNT_W=4: 20 beats of (1,0,0) → `out_beats`=15, `out_sum`=20.
